// File: rtl/handshake_pkg.sv
// Shared handshake types and elaboration helpers for the control-merge slice.
package handshake_pkg;

    // One handshake channel seen as a {valid, ready} pair; a transfer is valid & ready.
    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping at N-1.
module rr_priority_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] win,
    output logic [N-1:0] win_onehot
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   oh_rot;
    logic [2*N-1:0] oh_dbl;
    logic [W:0]     sel;
    logic [W:0]     sum;

    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N-1:0];
        // isolate the lowest set bit of the rotated request vector
        oh_rot  = req_rot & (~req_rot + N'(1));
        any     = |req_rot;
        sel     = '0;
        for (int unsigned j = N; j > 0; j--) begin
            if (req_rot[j-1]) begin
                sel = (W+1)'(j - 1);
            end
        end
        // rotate back by ptr with a single conditional subtract instead of modulo
        sum = {1'b0, ptr} + sel;
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        win        = sum[W-1:0];
        oh_dbl     = {oh_rot, oh_rot} << ptr;
        win_onehot = oh_dbl[2*N-1:N];
    end

endmodule

// File: rtl/handshake_control_merge_rr.sv
// Round-robin control merge: registered index token naming the granted requester.
module handshake_control_merge_rr
    import handshake_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_INPUTS-1:0]  ins_valid,
    output logic [NUM_INPUTS-1:0]  ins_ready,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   index_valid,
    input  logic                   index_ready
);

    if (INDEX_WIDTH < 1 || INDEX_WIDTH < int'(clog2(NUM_INPUTS))) begin : g_bad_width
        $error("INDEX_WIDTH too small for NUM_INPUTS");
    end

    hs_t                   out_hs;
    logic                  load;
    logic                  any;
    logic [INDEX_WIDTH-1:0] ptr;
    logic [INDEX_WIDTH-1:0] win;
    logic [NUM_INPUTS-1:0]  win_onehot;

    rr_priority_picker #(
        .N (NUM_INPUTS),
        .W (INDEX_WIDTH)
    ) u_picker (
        .req        (ins_valid),
        .ptr        (ptr),
        .any        (any),
        .win        (win),
        .win_onehot (win_onehot)
    );

    always_comb begin
        out_hs.valid = index_valid;
        out_hs.ready = index_ready;
        load         = !out_hs.valid || out_hs.ready;
        ins_ready    = (load && rst) ? win_onehot : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_valid <= 1'b0;
            index       <= '0;
            ptr         <= '0;
        end else if (load) begin
            if (any) begin
                index_valid <= 1'b1;
                index       <= win;
                ptr         <= (win == INDEX_WIDTH'(NUM_INPUTS - 1)) ? '0 : win + INDEX_WIDTH'(1);
            end else begin
                index_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_handshake_control_merge_rr.sv
// Bench for the round-robin control merge: behavioural model compared every cycle plus directed literals.
module tb_handshake_control_merge_rr;

    logic       clk;
    logic       rst;
    logic [3:0] v4;
    logic [3:0] rdy4;
    logic [1:0] idx4;
    logic       iv4;
    logic       r4;
    logic [2:0] v3;
    logic [2:0] rdy3;
    logic [1:0] idx3;
    logic       iv3;
    logic       r3;

    int checks   = 0;
    int failures = 0;

    handshake_control_merge_rr #(.NUM_INPUTS(4), .INDEX_WIDTH(2)) dut4 (
        .clk(clk), .rst(rst), .ins_valid(v4), .ins_ready(rdy4),
        .index(idx4), .index_valid(iv4), .index_ready(r4)
    );

    handshake_control_merge_rr #(.NUM_INPUTS(3), .INDEX_WIDTH(2)) dut3 (
        .clk(clk), .rst(rst), .ins_valid(v3), .ins_ready(rdy3),
        .index(idx3), .index_valid(iv3), .index_ready(r3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: plain modulo scan from the pointer; -1 means nobody is requesting.
    function automatic int pick(input logic [3:0] req, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            if (req[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    int m_ptr4, m_idx4, m_ptr3, m_idx3;
    bit m_v4, m_v3;
    int w4, w3;
    bit ld4, ld3;
    int exp_rdy4, exp_rdy3;

    always_comb begin
        ld4 = !m_v4 || r4;
        ld3 = !m_v3 || r3;
        w4  = pick(v4, m_ptr4, 4);
        w3  = pick({1'b0, v3}, m_ptr3, 3);
        exp_rdy4 = (rst && ld4 && w4 >= 0) ? (1 << w4) : 0;
        exp_rdy3 = (rst && ld3 && w3 >= 0) ? (1 << w3) : 0;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_v4 <= 0; m_idx4 <= 0; m_ptr4 <= 0;
            m_v3 <= 0; m_idx3 <= 0; m_ptr3 <= 0;
        end else begin
            if (ld4) begin
                if (w4 >= 0) begin
                    m_v4 <= 1; m_idx4 <= w4; m_ptr4 <= (w4 + 1) % 4;
                end else begin
                    m_v4 <= 0;
                end
            end
            if (ld3) begin
                if (w3 >= 0) begin
                    m_v3 <= 1; m_idx3 <= w3; m_ptr3 <= (w3 + 1) % 3;
                end else begin
                    m_v3 <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_ready4", int'(rdy4), exp_rdy4);
        chk("model_valid4", int'(iv4), int'(m_v4));
        chk("model_index4", int'(idx4), m_idx4);
        chk("model_ready3", int'(rdy3), exp_rdy3);
        chk("model_valid3", int'(iv3), int'(m_v3));
        chk("model_index3", int'(idx3), m_idx3);
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; v4 = 4'b1111; r4 = 1'b1; v3 = 3'b000; r3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", int'(rdy4), 0);
        chk("reset_valid", int'(iv4), 0);
        chk("reset_index", int'(idx4), 0);

        // all requesters valid, index_ready high: strict rotation on both widths
        rst = 1'b1; v3 = 3'b111;
        for (int k = 0; k < 8; k++) begin
            edge1();
            chk("rot_index4", int'(idx4), k % 4);
            chk("rot_valid4", int'(iv4), 1);
            chk("rot_ready4", int'(rdy4), 1 << ((k + 1) % 4));
            if (k < 6) chk("wrap_index3", int'(idx3), k % 3);
            chk("wrap_no_code3", int'(idx3 == 2'd3), 0);
        end
        v3 = 3'b000;

        // backpressure on requester 2
        v4 = 4'b0100; r4 = 1'b1;
        edge1();
        chk("bp_first", int'(idx4), 2);
        r4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            edge1();
            chk("bp_hold_index", int'(idx4), 2);
            chk("bp_hold_valid", int'(iv4), 1);
            chk("bp_hold_ready", int'(rdy4), 0);
        end
        r4 = 1'b1;
        #1;
        chk("bp_drain_ready", int'(rdy4), 4'b0100);
        edge1();
        chk("bp_next_index", int'(idx4), 2);
        chk("bp_next_valid", int'(iv4), 1);
        v4 = 4'b0000;
        edge1();
        chk("idle_valid", int'(iv4), 0);
        chk("idle_index_hold", int'(idx4), 2);
        v4 = 4'b1111;
        edge1();
        chk("ptr_after_bp", int'(idx4), 3);

        // sparse requests with wrap from ptr=2
        v4 = 4'b0010;
        edge1();
        chk("sparse_setup", int'(idx4), 1);
        v4 = 4'b0011;
        edge1();
        chk("sparse_wrap", int'(idx4), 0);
        v4 = 4'b0001;
        edge1();
        chk("sparse_again", int'(idx4), 0);
        v4 = 4'b0011;
        edge1();
        chk("sparse_ptr1", int'(idx4), 1);

        // asynchronous reset while stalled
        v4 = 4'b0100;
        edge1();
        chk("stall_setup", int'(idx4), 2);
        r4 = 1'b0;
        edge1();
        chk("stall_valid", int'(iv4), 1);
        #1 rst = 1'b0;
        #1;
        chk("async_valid", int'(iv4), 0);
        chk("async_index", int'(idx4), 0);
        chk("async_ready", int'(rdy4), 0);
        #1 rst = 1'b1; v4 = 4'b1111; r4 = 1'b1;
        edge1();
        chk("post_reset_ptr", int'(idx4), 0);

        v4 = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
